// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : MM:SS countdown timer. Holds the count as four BCD digits,
//               decrements once per second while running and raises an
//               alarm on reaching 00:00. Contains its own 1 s prescaler,
//               run/pause control FSM, BCD down-counter and 7-segment
//               encoders.
// Ports       : clk               - system clock, rising edge
//               rst               - synchronous reset, active low
//               load              - pulse, capture clamped preset
//               preset_min[6:0]   - preset minutes (binary, clamped to 99)
//               preset_sec[5:0]   - preset seconds (binary, clamped to 59)
//               start             - pulse, start/resume, acknowledge alarm
//               pause             - pulse, freeze counting
//               seg_*[7:0]        - 7-segment codes {dp, g..a}, active high
//               running           - high while counting
//               alarm             - high once 00:00 has been reached
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] preset_min,
    input  logic [5:0] preset_sec,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] seg_minutes_tens,
    output logic [7:0] seg_minutes_units,
    output logic [7:0] seg_seconds_tens,
    output logic [7:0] seg_seconds_units,
    output logic       running,
    output logic       alarm
);

    localparam int c_PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICKS_PER_SEC - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_PAUSED = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_PW-1:0] r_presc;
    logic [c_PW-1:0] w_presc_nxt;
    logic [3:0]      r_mt, r_mu, r_st, r_su;
    logic [3:0]      w_dec_mt, w_dec_mu, w_dec_st, w_dec_su;
    logic            w_borrow_s, w_borrow_t, w_borrow_u;
    logic            w_load_en;
    logic            w_dec_en;
    logic            w_tick;
    logic            w_count_zero;
    logic            w_last_sec;
    logic [6:0]      w_min_clamped;
    logic [6:0]      w_sec_clamped;
    logic [7:0]      w_min_bcd;
    logic [7:0]      w_sec_bcd;

    // Binary (0..99) to two BCD digits by repeated subtraction of ten.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [6:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, 4'(rem)};
    endfunction

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Preset clamp and conversion
    // ------------------------------------------------------------------
    assign w_min_clamped = (preset_min > 7'd99) ? 7'd99 : preset_min;
    assign w_sec_clamped = (preset_sec > 6'd59) ? 7'd59 : {1'b0, preset_sec};
    assign w_min_bcd     = bin_to_bcd(w_min_clamped);
    assign w_sec_bcd     = bin_to_bcd(w_sec_clamped);

    // ------------------------------------------------------------------
    // BCD down-count by one second; seconds tens wraps 0 -> 5.
    // Never used at 00:00, so the minutes-tens borrow cannot underflow.
    // ------------------------------------------------------------------
    assign w_borrow_s = (r_su == 4'd0);
    assign w_borrow_t = w_borrow_s && (r_st == 4'd0);
    assign w_borrow_u = w_borrow_t && (r_mu == 4'd0);
    assign w_dec_su   = w_borrow_s ? 4'd9 : r_su - 4'd1;
    assign w_dec_st   = !w_borrow_s ? r_st : ((r_st == 4'd0) ? 4'd5 : r_st - 4'd1);
    assign w_dec_mu   = !w_borrow_t ? r_mu : ((r_mu == 4'd0) ? 4'd9 : r_mu - 4'd1);
    assign w_dec_mt   = w_borrow_u ? r_mt - 4'd1 : r_mt;

    assign w_count_zero = (r_mt == 4'd0) && (r_mu == 4'd0) &&
                          (r_st == 4'd0) && (r_su == 4'd0);
    // The next decrement lands on 00:00.
    assign w_last_sec   = (r_mt == 4'd0) && (r_mu == 4'd0) &&
                          (r_st == 4'd0) && (r_su == 4'd1);
    assign w_tick       = (r_presc == c_PRESC_MAX);

    // ------------------------------------------------------------------
    // Control FSM: next state, prescaler next value, datapath enables.
    // Priority within a cycle is load > pause > start.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_load_en   = 1'b0;
        w_dec_en    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (load) begin
                    w_load_en = 1'b1;
                end else if (!pause && start && !w_count_zero) begin
                    w_state_nxt = c_ST_RUN;
                    w_presc_nxt = '0;
                end
            end
            c_ST_RUN: begin
                // The prescaler advances on the pause edge too, so the held
                // value already includes that cycle.
                if (w_tick) begin
                    w_presc_nxt = '0;
                    w_dec_en    = 1'b1;
                    if (w_last_sec) begin
                        w_state_nxt = c_ST_DONE;
                    end else if (pause) begin
                        w_state_nxt = c_ST_PAUSED;
                    end
                end else begin
                    w_presc_nxt = r_presc + c_PW'(1);
                    if (pause) begin
                        w_state_nxt = c_ST_PAUSED;
                    end
                end
            end
            c_ST_PAUSED: begin
                if (load) begin
                    w_load_en   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                    w_presc_nxt = '0;
                end else if (!pause && start) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_DONE: begin
                if (load) begin
                    w_load_en   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (!pause && start) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mt <= 4'd0;
            r_mu <= 4'd0;
            r_st <= 4'd0;
            r_su <= 4'd0;
        end else if (w_load_en) begin
            r_mt <= w_min_bcd[7:4];
            r_mu <= w_min_bcd[3:0];
            r_st <= w_sec_bcd[7:4];
            r_su <= w_sec_bcd[3:0];
        end else if (w_dec_en) begin
            r_mt <= w_dec_mt;
            r_mu <= w_dec_mu;
            r_st <= w_dec_st;
            r_su <= w_dec_su;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign running           = (r_state == c_ST_RUN);
    assign alarm             = (r_state == c_ST_DONE);
    assign seg_minutes_tens  = seg_encode(r_mt);
    assign seg_minutes_units = seg_encode(r_mu);
    assign seg_seconds_tens  = seg_encode(r_st);
    assign seg_seconds_units = seg_encode(r_su);

endmodule
`default_nettype wire
